serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter CLKFREQ, default 120_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 38400, meaning line bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port SERIAL_RX  input  1  asynchronous UART line, idle high.
REQ-006 SHALL have port RXData  output  8  byte at FIFO head (show-ahead).
REQ-007 SHALL have port RXValid  output  1  high while the FIFO is non-empty.
REQ-008 SHALL have port RXRead  input  1  pop the FIFO head when RXValid=1.
REQ-009 SHALL have port RXError  output  1  one-cycle pulse on framing error.
REQ-010 SHALL have port RXParityErr  output  1  one-cycle pulse on parity error.
REQ-011 SHALL have port RXOverrun  output  1  sticky flag for a byte lost to a full FIFO.

Function
REQ-012 SHALL pass SERIAL_RX through a 2-FF synchronizer; all decisions use the synchronized value.
REQ-013 SHALL generate an oversample tick every TICK=CLKFREQ/(BAUDRATE*16) clocks (integer division), giving 16 ticks per bit.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY (present only with the macro) and STOP.
REQ-015 IDLE: SHALL go to START on a synchronized 1->0 edge, restarting the tick divider and tick count.
REQ-016 START: at tick 8, line=1 SHALL be treated as a false start (return to IDLE, no flags); line=0 SHALL go to DATA with tick count restarted.
REQ-017 DATA: SHALL take each bit as the majority of samples at ticks 7, 8 and 9 of that bit, 8 bits, LSB first, 16 ticks per bit.
REQ-018 STOP: majority 1 SHALL push the byte; majority 0 SHALL discard the byte and pulse RXError.
REQ-019 After STOP, SHALL return to IDLE without waiting for the rest of the stop bit; a new start requires a fresh 1->0 edge.
REQ-020 The FIFO SHALL be 4 entries deep; RXValid SHALL rise the clock after the push.
REQ-021 RXRead with RXValid=1 SHALL pop the head; RXRead with RXValid=0 SHALL be ignored.
REQ-022 On push when full with no simultaneous pop, SHALL drop the new byte and set RXOverrun, held until rst.
REQ-023 On simultaneous push and pop when full, SHALL accept both, with no overrun.
REQ-024 Pointers SHALL wrap modulo 4; FIFO order SHALL be preserved across the wrap.

Reset
REQ-025 rst SHALL force: state=IDLE, FIFO empty, RXValid=0, RXData=0, RXError=0, RXParityErr=0, RXOverrun=0, synchronizer=11, divider and counters=0.
REQ-026 rst asserted mid-frame SHALL abort the frame without a push or any flag; after release, reception SHALL resume only on a new 1->0 edge.

Configuration
REQ-027 Macro SERIALRX_PARITY_EN defined: PARITY state between DATA and STOP, one even-parity bit sampled per REQ-017.
REQ-028 With the macro, a parity mismatch SHALL discard the byte and pulse RXParityErr; STOP SHALL still be checked, and RXError SHALL also pulse if the stop bit is 0.
REQ-029 Macro undefined: no PARITY state, frame is 8N1, RXParityErr tied 0.

Verification (CLKFREQ=120_000_000, BAUDRATE=38400, TICK=195, bit=3120 clk)
REQ-030 Send 0xA5 at 8N1 (3125-clk bits) -> RXValid=1, RXData=0xA5, flags=0; RXRead pulse -> RXValid=0.
REQ-031 Send 0x12,0x34,0x56,0x78,0x9A with no reads -> RXOverrun=1, FIFO reads 0x12,0x34,0x56,0x78, then RXValid=0.
REQ-032 Send 0x3C with stop bit driven 0 -> RXError one-cycle pulse, RXValid stays 0.
REQ-033 Drive a 1500-clk low glitch on idle line -> no push, no flags, state back to IDLE.
REQ-034 Assert rst for 1 clk in the middle of bit 4 of 0x55, then send 0x0F -> only 0x0F is received.
REQ-035 With SERIALRX_PARITY_EN: 0x07 with parity bit 0 -> RXParityErr pulse, no push; 0x07 with parity bit 1 -> 0x07 received.

Source files
------------

// File: rtl/serial_rx_if.sv
// Purpose : bundles the UART receive line and the receive-FIFO read side of
//           serial_rx into one interface.
// Signals : SERIAL_RX   - asynchronous UART line, idle high (toward receiver)
//           RXRead      - pop the FIFO head when RXValid is high
//           RXData      - byte at the FIFO head (show-ahead)
//           RXValid     - FIFO non-empty
//           RXError     - one-cycle pulse on a framing error
//           RXParityErr - one-cycle pulse on a parity error
//           RXOverrun   - sticky flag, a byte was lost to a full FIFO
// Modports: master (line driver / FIFO consumer), slave (the receiver).
interface serial_rx_if;
  logic       SERIAL_RX;
  logic       RXRead;
  logic [7:0] RXData;
  logic       RXValid;
  logic       RXError;
  logic       RXParityErr;
  logic       RXOverrun;

  modport master (
    output SERIAL_RX, RXRead,
    input  RXData, RXValid, RXError, RXParityErr, RXOverrun
  );

  modport slave (
    input  SERIAL_RX, RXRead,
    output RXData, RXValid, RXError, RXParityErr, RXOverrun
  );
endinterface

// File: rtl/serial_rx.sv
// Purpose : 16x-oversampling UART receiver (8N1, or 8E1 with the parity
//           option) feeding a 4-entry show-ahead receive FIFO.
// Ports   : clk - single clock, all logic on its rising edge
//           rst - synchronous active-high reset
//           bus - serial_rx_if.slave (SERIAL_RX in; RXData/RXValid/RXRead
//                 FIFO read side; RXError/RXParityErr pulses; RXOverrun)
// Params  : CLKFREQ (Hz), BAUDRATE (bit/s); tick = CLKFREQ/(BAUDRATE*16).
// Option  : define SERIALRX_PARITY_EN to add one even-parity bit between the
//           data and stop bits; otherwise RXParityErr is tied low.
module serial_rx #(
  parameter int unsigned CLKFREQ  = 120_000_000,
  parameter int unsigned BAUDRATE = 38400
) (
  input logic        clk,
  input logic        rst,
  serial_rx_if.slave bus
);

  localparam int unsigned TICK  = CLKFREQ / (BAUDRATE * 16);
  localparam int unsigned DIV_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;

`ifdef SERIALRX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Line synchronizer and edge detect
  logic [1:0]       r_sync;
  logic             r_rx_q;
  logic             w_rx;
  logic             w_fall;

  // Oversample timing
  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic [3:0]       r_tcnt;
  logic [4:0]       w_tnum;

  // Frame assembly
  state_t           r_state;
  logic [2:0]       r_bitidx;
  logic [7:0]       r_shift;
  logic             r_s7;
  logic             r_s8;
  logic             w_maj;
  logic             r_push;
  logic [7:0]       r_push_data;
  logic             r_err;
  logic             w_par_bad;
`ifdef SERIALRX_PARITY_EN
  logic             r_par_bad;
  logic             r_perr;
`endif

  // FIFO
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic [7:0]       r_data;
  logic             r_ovr;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic [PTR_W-1:0] w_rp_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [7:0]       w_head_next;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_q & ~w_rx;
  assign w_tick = (r_div == DIV_W'(TICK - 1));
  // Number of the tick occurring this cycle, counted from 1 within a bit
  assign w_tnum = 5'(r_tcnt) + 5'd1;
  // Majority of the samples at ticks 7, 8 and the current tick 9
  assign w_maj  = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);

`ifdef SERIALRX_PARITY_EN
  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  // Receive FSM: the start bit runs its full 16 ticks (with the false-start
  // check at its centre) so every later bit window starts on a bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= 2'b11;
      r_rx_q      <= 1'b1;
      r_div       <= '0;
      r_tcnt      <= '0;
      r_state     <= S_IDLE;
      r_bitidx    <= '0;
      r_shift     <= '0;
      r_s7        <= 1'b0;
      r_s8        <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_err       <= 1'b0;
`ifdef SERIALRX_PARITY_EN
      r_par_bad   <= 1'b0;
      r_perr      <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[0], bus.SERIAL_RX};
      r_rx_q <= w_rx;
      r_push <= 1'b0;
      r_err  <= 1'b0;
`ifdef SERIALRX_PARITY_EN
      r_perr <= 1'b0;
`endif
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) r_tcnt <= r_tcnt + 4'd1;

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_div   <= '0;
            r_tcnt  <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (w_tnum == 5'd8 && w_rx) begin
              r_state <= S_IDLE;
            end else if (w_tnum == 5'd16) begin
              r_state  <= S_DATA;
              r_tcnt   <= '0;
              r_bitidx <= '0;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            case (w_tnum)
              5'd7:  r_s7 <= w_rx;
              5'd8:  r_s8 <= w_rx;
              5'd9:  r_shift <= {w_maj, r_shift[7:1]};
              5'd16: begin
                r_tcnt <= '0;
                if (r_bitidx == 3'd7) begin
`ifdef SERIALRX_PARITY_EN
                  r_state <= S_PARITY;
`else
                  r_state <= S_STOP;
`endif
                end else begin
                  r_bitidx <= r_bitidx + 3'd1;
                end
              end
              default: ;
            endcase
          end
        end
`ifdef SERIALRX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            case (w_tnum)
              5'd7:  r_s7 <= w_rx;
              5'd8:  r_s8 <= w_rx;
              // Even parity: data bits plus parity bit must XOR to 0
              5'd9:  r_par_bad <= w_maj ^ (^r_shift);
              5'd16: begin
                r_tcnt  <= '0;
                r_state <= S_STOP;
              end
              default: ;
            endcase
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            case (w_tnum)
              5'd7: r_s7 <= w_rx;
              5'd8: r_s8 <= w_rx;
              // Decide at the stop centre and go idle without waiting out the bit
              5'd9: begin
                r_push      <= w_maj & ~w_par_bad;
                r_push_data <= r_shift;
                r_err       <= ~w_maj;
`ifdef SERIALRX_PARITY_EN
                r_perr      <= r_par_bad;
`endif
                r_state     <= S_IDLE;
              end
              default: ;
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO control; a push into a full FIFO lands only if the head pops together
  assign w_pop      = bus.RXRead & r_valid;
  assign w_full     = (r_cnt == CNT_W'(DEPTH));
  assign w_wr       = r_push & (~w_full | w_pop);
  assign w_rp_next  = w_pop ? r_rp + PTR_W'(1) : r_rp;
  assign w_cnt_next = r_cnt + CNT_W'(w_wr) - CNT_W'(w_pop);
  // Bypass when the byte being written becomes the new head
  assign w_head_next = (w_wr && (w_rp_next == r_wp)) ? r_push_data : r_mem[w_rp_next];

  // FIFO storage, pointers and registered head/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= r_push_data;
        r_wp        <= r_wp + PTR_W'(1);
      end
      r_rp    <= w_rp_next;
      r_cnt   <= w_cnt_next;
      r_valid <= (w_cnt_next != '0);
      r_data  <= (w_cnt_next == '0) ? 8'h00 : w_head_next;
      if (r_push && w_full && !w_pop) r_ovr <= 1'b1;
    end
  end

  assign bus.RXData    = r_data;
  assign bus.RXValid   = r_valid;
  assign bus.RXError   = r_err;
  assign bus.RXOverrun = r_ovr;
`ifdef SERIALRX_PARITY_EN
  assign bus.RXParityErr = r_perr;
`else
  assign bus.RXParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Testbench for serial_rx: drives whole UART frames at a slightly slow sender
// rate and checks the receive FIFO against a byte-queue model every idle cycle.
module tb_serial_rx;

  localparam int unsigned CLKF     = 2_000_000;
  localparam int unsigned BAUD     = 12_000;   // tick = 10 clk, bit = 160 clk
  localparam int          BIT_CLKS = 161;      // sender bit period, a bit slow

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_rx_if bus ();

  serial_rx #(.CLKFREQ(CLKF), .BAUDRATE(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: bytes the FIFO must hold, in order, plus the sticky overrun flag
  logic [7:0] q[$];
  bit         m_ovr;
  bit         settled;
  int         err_cyc;
  int         perr_cyc;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Count error-pulse cycles so each frame can check pulse count and width
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.RXError)     err_cyc++;
      if (bus.RXParityErr) perr_cyc++;
    end
  end

  // Per-cycle comparison while no frame is on the line
  always @(negedge clk) begin
    if (settled && !rst) begin
      check("valid", int'(bus.RXValid), int'(q.size() != 0));
      if (q.size() != 0) check("data", int'(bus.RXData), int'(q[0]));
      check("overrun", int'(bus.RXOverrun), int'(m_ovr));
      check("err_idle", int'(bus.RXError), 0);
      check("perr_idle", int'(bus.RXParityErr), 0);
    end
  end

  task automatic model_push(input logic [7:0] d);
    if (q.size() == 4) m_ovr = 1'b1;
    else q.push_back(d);
  endtask

  // Send nb bits of fr LSB first, then settle and apply the expected outcome
  task automatic send_raw(input logic [10:0] fr, input int nb, input logic [7:0] d,
                          input int exp_err, input int exp_perr, input int gap);
    settled  = 1'b0;
    err_cyc  = 0;
    perr_cyc = 0;
    for (int i = 0; i < nb; i++) begin
      bus.SERIAL_RX = fr[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    bus.SERIAL_RX = 1'b1;
    check("err_pulse", err_cyc, exp_err);
    check("perr_pulse", perr_cyc, exp_perr);
    if (exp_err == 0 && exp_perr == 0) model_push(d);
    settled = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb, input int gap);
    logic [10:0] fr;
`ifdef SERIALRX_PARITY_EN
    fr = {stopb, ^d, d, 1'b0};
    send_raw(fr, 11, d, stopb ? 0 : 1, 0, gap);
`else
    fr = {1'b1, stopb, d, 1'b0};
    send_raw(fr, 10, d, stopb ? 0 : 1, 0, gap);
`endif
  endtask

  // Check the head against a literal, then pop it with a one-cycle RXRead
  task automatic read_expect(input string name, input logic [7:0] lit);
    check({name, "_dut"}, int'(bus.RXData), int'(lit));
    check({name, "_model"}, (q.size() != 0) ? int'(q[0]) : -1, int'(lit));
    bus.RXRead = 1'b1;
    @(posedge clk);
    #1;
    bus.RXRead = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.SERIAL_RX = 1'b1;
    bus.RXRead    = 1'b0;
    settled       = 1'b0;
    m_ovr         = 1'b0;
    err_cyc       = 0;
    perr_cyc      = 0;
    idle(3);
    check("rst_valid", int'(bus.RXValid), 0);
    check("rst_data", int'(bus.RXData), 0);
    check("rst_err", int'(bus.RXError), 0);
    check("rst_perr", int'(bus.RXParityErr), 0);
    check("rst_ovr", int'(bus.RXOverrun), 0);
    rst     = 1'b0;
    settled = 1'b1;
    idle(40);

    // Single byte, then pop; an extra read on an empty FIFO is ignored
    send_frame(8'hA5, 1'b1, 30);
    check("a5_valid", int'(bus.RXValid), 1);
    read_expect("a5", 8'hA5);
    idle(3);
    check("a5_empty", int'(bus.RXValid), 0);
    bus.RXRead = 1'b1;
    idle(1);
    bus.RXRead = 1'b0;
    idle(20);

    // Five bytes with no reads: the fifth is lost, order kept across the wrap
    send_frame(8'h12, 1'b1, 20);
    send_frame(8'h34, 1'b1, 20);
    send_frame(8'h56, 1'b1, 20);
    send_frame(8'h78, 1'b1, 20);
    send_frame(8'h9A, 1'b1, 20);
    check("ovr_flag", int'(bus.RXOverrun), 1);
    read_expect("ovr0", 8'h12);
    read_expect("ovr1", 8'h34);
    read_expect("ovr2", 8'h56);
    read_expect("ovr3", 8'h78);
    idle(2);
    check("ovr_drained", int'(bus.RXValid), 0);
    check("ovr_sticky", int'(bus.RXOverrun), 1);

    // Framing error: stop bit driven low
    send_frame(8'h3C, 1'b0, 30);
    check("fe_valid", int'(bus.RXValid), 0);

    // Short low glitch on an idle line is a false start
    settled  = 1'b0;
    err_cyc  = 0;
    perr_cyc = 0;
    bus.SERIAL_RX = 1'b0;
    idle(70);
    bus.SERIAL_RX = 1'b1;
    idle(2 * BIT_CLKS);
    check("gl_err", err_cyc, 0);
    check("gl_perr", perr_cyc, 0);
    settled = 1'b1;
    idle(10);
    check("gl_valid", int'(bus.RXValid), 0);
    send_frame(8'h5A, 1'b1, 20);
    read_expect("gl_next", 8'h5A);

    // Reset in the middle of bit 4 of 0x55 aborts it; then 0x0F is received
    settled  = 1'b0;
    err_cyc  = 0;
    perr_cyc = 0;
    bus.SERIAL_RX = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      bus.SERIAL_RX = (i % 2 == 0) ? 1'b1 : 1'b0;
      idle(BIT_CLKS);
    end
    bus.SERIAL_RX = 1'b1;
    idle(BIT_CLKS / 2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    idle(3 * BIT_CLKS);
    check("mr_err", err_cyc, 0);
    check("mr_perr", perr_cyc, 0);
    check("mr_valid", int'(bus.RXValid), 0);
    check("mr_ovr", int'(bus.RXOverrun), 0);
    settled = 1'b1;
    idle(10);
    send_frame(8'h0F, 1'b1, 20);
    read_expect("mr_0f", 8'h0F);
    idle(2);
    check("mr_empty", int'(bus.RXValid), 0);

`ifdef SERIALRX_PARITY_EN
    // 0x07 has three ones, so even parity needs parity bit 1
    send_raw({1'b1, 1'b0, 8'h07, 1'b0}, 11, 8'h07, 0, 1, 30);
    check("pe_valid", int'(bus.RXValid), 0);
    send_raw({1'b1, 1'b1, 8'h07, 1'b0}, 11, 8'h07, 0, 0, 30);
    read_expect("pe_ok", 8'h07);
`endif

    settled = 1'b0;
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
